// File: rtl/gate_truth_checker.sv
// Truth-table checker for a 2-input gate block: sweeps a,b over 00..11 and flags per-gate mismatches.
// Optional first-failure capture is built only when GATE_CHECK_FAIL_CAPTURE_EN is defined.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       drv_a,
  output logic       drv_b,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       not_in,
  input  logic       nand_in,
  input  logic       nor_in,
  input  logic       xor_in,
  input  logic       xnor_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_mask,
  output logic [1:0] fail_vec,
  output logic [6:0] fail_mask
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_FINISH
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] drv_q, drv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [6:0] err_q, err_d;

  logic       a, b;
  logic [6:0] gate_rsp;
  logic [6:0] expected;
  logic [6:0] mismatch;

  assign a        = drv_q[1];
  assign b        = drv_q[0];
  assign gate_rsp = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in};
  assign expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign mismatch = expected ^ gate_rsp;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_APPLY;
          vec_d   = 2'd0;
          drv_d   = 2'd0;
          err_d   = 7'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_APPLY: begin
        cnt_d   = SETTLE_LD;
        state_d = (SETTLE_LD != 4'd0) ? S_SETTLE : S_CHECK;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_CHECK;
      end
      S_CHECK: begin
        err_d = err_q | mismatch;
        if (vec_q == 2'd3) begin
          state_d = S_FINISH;
        end else begin
          vec_d   = vec_q + 2'd1;
          drv_d   = vec_q + 2'd1;
          state_d = S_APPLY;
        end
      end
      S_FINISH: begin
        // done/pass/busy are registered, so they land together on the edge leaving FINISH
        state_d = S_IDLE;
        drv_d   = 2'd0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == 7'd0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      drv_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign drv_a    = drv_q[1];
  assign drv_b    = drv_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_mask = err_q;

`ifdef GATE_CHECK_FAIL_CAPTURE_EN
  logic [1:0] fvec_q, fvec_d;
  logic [6:0] fmask_q, fmask_d;

  // A captured mask is never zero, so a zero mask means nothing captured yet this run
  always_comb begin
    fvec_d  = fvec_q;
    fmask_d = fmask_q;
    if (state_q == S_IDLE && start) begin
      fvec_d  = 2'd0;
      fmask_d = 7'd0;
    end else if (state_q == S_CHECK && mismatch != 7'd0 && fmask_q == 7'd0) begin
      fvec_d  = vec_q;
      fmask_d = mismatch;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fvec_q  <= 2'd0;
      fmask_q <= 7'd0;
    end else begin
      fvec_q  <= fvec_d;
      fmask_q <= fmask_d;
    end
  end

  assign fail_vec  = fvec_q;
  assign fail_mask = fmask_q;
`else
  assign fail_vec  = 2'd0;
  assign fail_mask = 7'd0;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: injectable gate faults, cycle-accurate run model, directed runs.
module tb_gate_truth_checker;
  localparam int SC = 2;
  localparam int P  = SC + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;
  always #5 clk = ~clk;

  logic       drv_a, drv_b, busy, done, pass;
  logic [6:0] err_mask, fail_mask, rsp;
  logic [1:0] fail_vec;
  logic       drv_a0, drv_b0, busy0, done0, pass0;
  logic [6:0] err0, fm0, rsp0;
  logic [1:0] fv0;
  logic [3:0] fault = 4'd0;  // [0] and stuck-0, [1] xor inverted, [2] not stuck-1, [3] nor stuck-1

  int checks = 0;
  int errors = 0;

  // Ideal responses, bit order xnor,xor,nor,nand,not,or,and
  function automatic logic [6:0] ideal(input logic [1:0] ab);
    case (ab)
      2'b00:   return 7'h5C;
      2'b01:   return 7'h2E;
      2'b10:   return 7'h2A;
      default: return 7'h43;
    endcase
  endfunction

  function automatic logic [6:0] gate_blk(input logic [3:0] f, input logic [1:0] ab);
    logic [6:0] r;
    r = ideal(ab);
    if (f[0]) r[0] = 1'b0;
    if (f[1]) r[5] = ~r[5];
    if (f[2]) r[2] = 1'b1;
    if (f[3]) r[4] = 1'b1;
    return r;
  endfunction

  assign rsp  = gate_blk(fault, {drv_a, drv_b});
  assign rsp0 = ideal({drv_a0, drv_b0});

  gate_truth_checker #(.SETTLE_CYCLES(SC)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .drv_a(drv_a), .drv_b(drv_b),
    .and_in(rsp[0]), .or_in(rsp[1]), .not_in(rsp[2]), .nand_in(rsp[3]),
    .nor_in(rsp[4]), .xor_in(rsp[5]), .xnor_in(rsp[6]),
    .busy(busy), .done(done), .pass(pass), .err_mask(err_mask),
    .fail_vec(fail_vec), .fail_mask(fail_mask)
  );

  gate_truth_checker #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .drv_a(drv_a0), .drv_b(drv_b0),
    .and_in(rsp0[0]), .or_in(rsp0[1]), .not_in(rsp0[2]), .nand_in(rsp0[3]),
    .nor_in(rsp0[4]), .xor_in(rsp0[5]), .xnor_in(rsp0[6]),
    .busy(busy0), .done(done0), .pass(pass0), .err_mask(err0),
    .fail_vec(fv0), .fail_mask(fm0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Run model: k counts cycles since start acceptance; vector v occupies k in [v*P, v*P+P-1],
  // its last cycle is the check; k==4P is the finishing cycle, done shows one cycle later.
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [6:0] m_err = 7'd0, m_fm = 7'd0, m_mm;
  logic [1:0] m_fv = 2'd0;
  logic       m_pass = 1'b0, m_done = 1'b0;
  int         m_v;

  task automatic model_step();
    if (!rst_n) begin
      m_active = 1'b0; m_k = 0; m_err = 7'd0; m_pass = 1'b0; m_done = 1'b0;
      m_fv = 2'd0; m_fm = 7'd0;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1; m_k = 0; m_err = 7'd0; m_pass = 1'b0; m_fv = 2'd0; m_fm = 7'd0;
        end
      end else begin
        if (m_k < 4 * P && (m_k % P) == P - 1) begin
          m_v   = m_k / P;
          m_mm  = ideal(2'(m_v)) ^ gate_blk(fault, 2'(m_v));
          m_err = m_err | m_mm;
`ifdef GATE_CHECK_FAIL_CAPTURE_EN
          if (m_mm != 7'd0 && m_fm == 7'd0) begin
            m_fv = 2'(m_v);
            m_fm = m_mm;
          end
`endif
        end
        if (m_k == 4 * P) begin
          m_done = 1'b1; m_pass = (m_err == 7'd0); m_active = 1'b0;
        end else begin
          m_k++;
        end
      end
    end
  endtask

  initial begin
    logic [1:0] m_drv;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      m_v   = (m_k / P > 3) ? 3 : m_k / P;
      m_drv = m_active ? 2'(m_v) : 2'd0;
      chk("ctl", {busy, done, pass, drv_a, drv_b}, {m_active, m_done, m_pass, m_drv});
      chk("err_mask", err_mask, m_err);
      chk("fail_cap", {fail_vec, fail_mask}, {m_fv, m_fm});
    end
  end

  task automatic run(input bit repulse, output int done_at, output int ndone);
    done_at = -1;
    ndone = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int n = 1; n <= 4 * P + 8; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
      @(negedge clk);
      start = repulse && (n == 2 || n == 9);
    end
    start = 1'b0;
  endtask

  task automatic chk_capture(input logic [1:0] fv, input logic [6:0] fm);
`ifdef GATE_CHECK_FAIL_CAPTURE_EN
    chk("lit_fail_vec", fail_vec, fv);
    chk("lit_fail_mask", fail_mask, fm);
`else
    chk("lit_fail_vec", fail_vec, 2'd0);
    chk("lit_fail_mask", fail_mask, 7'd0);
`endif
  endtask

  initial begin
    int at, nd;
    repeat (2) @(negedge clk);
    chk("rst_outs", {busy, done, pass, drv_a, drv_b, err_mask}, 12'd0);
    rst_n = 1'b1;

    // ideal gates
    run(1'b0, at, nd);
    chk("ideal_done_cycle", at, 17);
    chk("ideal_done_count", nd, 1);
    chk("ideal_result", {pass, busy, err_mask}, {1'b1, 1'b0, 7'h00});
    chk_capture(2'b00, 7'h00);

    fault = 4'b0001;
    run(1'b0, at, nd);
    chk("and_s0_result", {pass, err_mask}, {1'b0, 7'h01});
    chk_capture(2'b11, 7'h01);

    fault = 4'b0010;
    run(1'b0, at, nd);
    chk("xor_inv_result", {pass, err_mask}, {1'b0, 7'h20});
    chk_capture(2'b00, 7'h20);

    fault = 4'b0100;
    run(1'b0, at, nd);
    chk("not_s1_result", {pass, err_mask}, {1'b0, 7'h04});
    chk_capture(2'b10, 7'h04);

    fault = 4'b1001;
    run(1'b0, at, nd);
    chk("and_nor_result", {pass, err_mask}, {1'b0, 7'h11});
    chk_capture(2'b01, 7'h10);

    // start pulses mid-run are ignored
    fault = 4'b0000;
    run(1'b1, at, nd);
    chk("repulse_done_cycle", at, 17);
    chk("repulse_done_count", nd, 1);
    chk("repulse_result", {pass, err_mask}, {1'b1, 7'h00});

    // reset during SETTLE of vector 2, with start held high under reset
    fault = 4'b0001;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_vec2", {busy, drv_a, drv_b}, 3'b110);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun_rst", {busy, done, pass, drv_a, drv_b, err_mask}, 12'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    nd = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("rst_no_done", nd, 0);
    chk("rst_idle", {busy, drv_a, drv_b}, 3'b000);
    fault = 4'b0000;
    run(1'b0, at, nd);
    chk("post_rst_done_cycle", at, 17);
    chk("post_rst_result", {pass, err_mask}, {1'b1, 7'h00});

    // zero-settle instance
    at = -1;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done0 && at < 0) at = n;
    end
    chk("s0_done_cycle", at, 9);
    chk("s0_result", {pass0, busy0, err0, fv0, fm0}, {1'b1, 1'b0, 7'h00, 2'd0, 7'h00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, idle cycles between applying a vector and sampling gate outputs; legal range 0..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request one full truth-table run; sampled only in IDLE.
REQ-005 drv_a  output  1  operand a driven to gate block under test.
REQ-006 drv_b  output  1  operand b driven to gate block under test.
REQ-007 and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in  input  1 each  gate responses from block under test.
REQ-008 busy  output  1  high from start acceptance until FINISH is left.
REQ-009 done  output  1  one-cycle pulse at end of run.
REQ-010 pass  output  1  high when last completed run had no mismatches.
REQ-011 err_mask  output  7  sticky per-gate mismatch flags; bit order [0]and [1]or [2]not [3]nand [4]nor [5]xor [6]xnor.
REQ-012 fail_vec  output  2  {a,b} of first failing vector (see Configuration).
REQ-013 fail_mask  output  7  mismatch bits at first failing vector, same bit order as err_mask.

Function
REQ-014 FSM states IDLE, APPLY, SETTLE, CHECK, FINISH; 2-bit vector index vec, 4-bit settle counter.
REQ-015 IDLE: drv_a=drv_b=0, busy=0; start=1 -> APPLY, vec=0, err_mask cleared, pass cleared, fail capture cleared.
REQ-016 Vector order 00,01,10,11 with drv_a=vec[1], drv_b=vec[0].
REQ-017 APPLY: drive vector for 1 cycle, load settle counter with SETTLE_CYCLES; -> SETTLE if SETTLE_CYCLES>0 else CHECK.
REQ-018 SETTLE: hold vector, decrement each cycle; counter reaching 1 -> CHECK (exactly SETTLE_CYCLES cycles in SETTLE).
REQ-019 CHECK: 1 cycle; expected = {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b} from drv_a/drv_b; err_mask |= expected ^ inputs.
REQ-020 CHECK with vec<3 -> APPLY with vec+1; vec==3 -> FINISH.
REQ-021 Per-vector cost SETTLE_CYCLES+2 cycles; done high in the cycle beginning 4*(SETTLE_CYCLES+2)+1 edges after the edge that sampled start.
REQ-022 FINISH: 1 cycle, done=1, pass=(final err_mask==0); -> IDLE.
REQ-023 pass, err_mask, fail_vec, fail_mask hold after FINISH until next start accepted.
REQ-024 start while busy (APPLY..FINISH) ignored; no queuing, no restart.
REQ-025 drv_a/drv_b change only on entry to APPLY or IDLE; stable through SETTLE and CHECK.

Reset
REQ-026 rst_n=0 at any edge, including mid-run: state=IDLE, vec=0, counter=0, drv_a=drv_b=0, busy=0, done=0, pass=0, err_mask=0, fail_vec=0, fail_mask=0.
REQ-027 start coincident with rst_n=0 ignored; reset wins.

Configuration
REQ-028 Macro GATE_CHECK_FAIL_CAPTURE_EN: defined -> at first CHECK with nonzero mismatch in a run, fail_vec=vec and fail_mask=mismatch latched, later failures do not overwrite.
REQ-029 Macro undefined -> fail_vec and fail_mask tied to 0, capture logic absent; all other behaviour identical.

Verification
REQ-030 Ideal gate model attached, SETTLE_CYCLES=2, start pulse -> done at cycle 17, pass=1, err_mask=7'h00, busy low next cycle.
REQ-031 and_in stuck-at-0 -> err_mask=7'h01, pass=0; with macro fail_vec=2'b11, fail_mask=7'h01.
REQ-032 xor_in inverted -> err_mask=7'h20, pass=0; with macro fail_vec=2'b00, fail_mask=7'h20; without macro fail_vec=0, fail_mask=0.
REQ-033 rst_n low during SETTLE of vec=2 -> after that edge busy=0, drv_a=drv_b=0, err_mask=0, no done pulse; new start completes a normal run.
REQ-034 start re-pulsed at cycles 3 and 10 of a run -> exactly one done pulse at cycle 17; SETTLE_CYCLES=0 build -> done at cycle 9.
